// File: rtl/ror_seq_ctrl_if.sv
// Requester-side bus for the shared rotate sequencer: two request/operand
// channels in, acks, status and the registered result with flags out.
interface ror_seq_ctrl_if;
  logic       req0;
  logic [4:0] a0;
  logic [2:0] shift0;
  logic       req1;
  logic [4:0] a1;
  logic [2:0] shift1;
  logic       ack0;
  logic       ack1;
  logic       busy;
  logic       done;
  logic       done_id;
  logic [4:0] z;
  logic       cf;
  logic       sf;
  logic       zf;

  modport master (
    output req0, a0, shift0, req1, a1, shift1,
    input  ack0, ack1, busy, done, done_id, z, cf, sf, zf
  );

  modport slave (
    input  req0, a0, shift0, req1, a1, shift1,
    output ack0, ack1, busy, done, done_id, z, cf, sf, zf
  );
endinterface

// File: rtl/ror_seq_ctrl.sv
// Round-robin shared 5-bit rotate-right sequencer: one bit per clock,
// result and flags registered on completion with a tagged done strobe.
module ror_seq_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  ror_seq_ctrl_if.slave bus
);

  localparam int unsigned DW = 5;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   acc, acc_next;
  logic [CW-1:0]   rem, rem_next;
  logic            gid, gid_next;
  logic            prio, prio_next;

  logic            grant;
  logic            sel_id;
  logic [DW-1:0]   sel_a;
  logic [CW-1:0]   sel_shift;
  logic [CW-1:0]   sel_rem;

  // Arbitration: lone requester wins, contention resolved by prio.
  always_comb begin
    sel_id    = (bus.req0 & bus.req1) ? prio : bus.req1;
    sel_a     = sel_id ? bus.a1 : bus.a0;
    sel_shift = sel_id ? bus.shift1 : bus.shift0;
    sel_rem   = (sel_shift >= CW'(5)) ? CW'(sel_shift - CW'(5)) : sel_shift;
    grant     = (state == IDLE) & (bus.req0 | bus.req1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant) state_next = (sel_rem != CW'(0)) ? ROT : DONE;
      ROT:  if (rem == CW'(1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ack0 = grant & ~sel_id;
    bus.ack1 = grant & sel_id;
  end

  // Datapath next values; rem only decrements while ROT, where it is >= 1.
  always_comb begin
    acc_next  = acc;
    rem_next  = rem;
    gid_next  = gid;
    prio_next = prio;
    case (state)
      IDLE: if (grant) begin
        acc_next  = sel_a;
        rem_next  = sel_rem;
        gid_next  = sel_id;
        prio_next = ~sel_id;
      end
      ROT: begin
        acc_next = {acc[0], acc[DW-1:1]};
        if (rem != CW'(0)) rem_next = CW'(rem - CW'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      rem  <= '0;
      gid  <= 1'b0;
      prio <= 1'b0;
    end else begin
      acc  <= acc_next;
      rem  <= rem_next;
      gid  <= gid_next;
      prio <= prio_next;
    end
  end

  // Result captured on entry to DONE so z is valid alongside the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.done_id <= 1'b0;
      bus.z       <= '0;
    end else begin
      bus.busy <= (state_next != IDLE);
      bus.done <= (state_next == DONE);
      if (state_next == DONE) begin
        bus.z       <= acc_next;
        bus.done_id <= gid_next;
      end
    end
  end

  assign bus.cf = 1'b0;
  assign bus.sf = bus.z[DW-1];
  assign bus.zf = (bus.z == DW'(0));

endmodule

// File: tb/tb_ror_seq_ctrl.sv
// Bench for ror_seq_ctrl: cycle-level transaction model checked every cycle,
// directed literal cases, then randomized requests with occasional resets.
module tb_ror_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ror_seq_ctrl_if bus();
  ror_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] rotr(input logic [4:0] a, input int n);
    logic [9:0] d;
    d = {a, a};
    d = d >> n;
    return d[4:0];
  endfunction

  // Model: each accept books its done cycle, busy window and next free cycle.
  int         cyc = 0;
  int         done_at = -1;
  int         busy_from = 1;
  int         busy_to = 0;
  int         next_free = 0;
  logic       m_prio = 1'b0;
  logic [4:0] m_z = '0;
  logic       m_id = 1'b0;
  logic [4:0] pend_z = '0;
  logic       pend_id = 1'b0;

  logic saw_ack0 = 1'b0;
  logic saw_ack1 = 1'b0;
  int   last_acc = -1;
  int   last_done = -1;
  int   busy_cnt = 0;

  always @(negedge clk) begin
    logic       e_ack0, e_ack1, id;
    logic [4:0] a;
    logic [2:0] sh;
    int         n;
    if (!rst_n) begin
      done_at = -1; busy_from = 1; busy_to = 0; next_free = 0;
      m_prio = 1'b0; m_z = '0; m_id = 1'b0;
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_done", 32'(bus.done), 32'(0));
      chk("rst_z", 32'(bus.z), 32'(0));
      chk("rst_done_id", 32'(bus.done_id), 32'(0));
      chk("rst_zf", 32'(bus.zf), 32'(1));
      chk("rst_sf", 32'(bus.sf), 32'(0));
      saw_ack0 = 1'b0;
      saw_ack1 = 1'b0;
    end else begin
      if (cyc == done_at) begin
        m_z  = pend_z;
        m_id = pend_id;
      end
      chk("busy", 32'(bus.busy), 32'(cyc >= busy_from && cyc <= busy_to));
      chk("done", 32'(bus.done), 32'(cyc == done_at));
      chk("z", 32'(bus.z), 32'(m_z));
      chk("done_id", 32'(bus.done_id), 32'(m_id));
      chk("sf", 32'(bus.sf), 32'(m_z[4]));
      chk("zf", 32'(bus.zf), 32'(m_z == 5'd0));
      chk("cf", 32'(bus.cf), 32'(0));
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      if (cyc >= next_free && (bus.req0 || bus.req1)) begin
        id = (bus.req0 && bus.req1) ? m_prio : bus.req1;
        a  = id ? bus.a1 : bus.a0;
        sh = id ? bus.shift1 : bus.shift0;
        n  = int'(sh) % 5;
        pend_z    = rotr(a, n);
        pend_id   = id;
        done_at   = cyc + 1 + n;
        busy_from = cyc + 1;
        busy_to   = cyc + 1 + n;
        next_free = cyc + 2 + n;
        m_prio    = ~id;
        if (id) e_ack1 = 1'b1;
        else    e_ack0 = 1'b1;
      end
      chk("ack0", 32'(bus.ack0), 32'(e_ack0));
      chk("ack1", 32'(bus.ack1), 32'(e_ack1));
      chk("ack_excl", 32'(bus.ack0 & bus.ack1), 32'(0));
      saw_ack0 = bus.ack0;
      saw_ack1 = bus.ack1;
      if (bus.ack0 || bus.ack1) begin
        last_acc = cyc;
        busy_cnt = 0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) last_done = cyc;
    end
    cyc++;
  end

  // Single request with literal expectations on latency, busy span and result.
  task automatic do_req(input logic id, input logic [4:0] a, input logic [2:0] sh,
                        input logic [4:0] ez, input int elat, input int ebusy,
                        input logic esf, input logic ezf);
    int k;
    if (id) begin bus.req1 = 1'b1; bus.a1 = a; bus.shift1 = sh; end
    else    begin bus.req0 = 1'b1; bus.a0 = a; bus.shift0 = sh; end
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!(id ? saw_ack1 : saw_ack0) && k < 20);
    chk("lit_ack", 32'(id ? saw_ack1 : saw_ack0), 32'(1));
    if (id) bus.req1 = 1'b0;
    else    bus.req0 = 1'b0;
    k = 0;
    while (last_done <= last_acc && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("lit_latency", 32'(last_done - last_acc), 32'(elat));
    chk("lit_busy_cycles", 32'(busy_cnt), 32'(ebusy));
    chk("lit_z", 32'(bus.z), 32'(ez));
    chk("lit_sf", 32'(bus.sf), 32'(esf));
    chk("lit_zf", 32'(bus.zf), 32'(ezf));
    chk("lit_cf", 32'(bus.cf), 32'(0));
    chk("lit_done_id", 32'(bus.done_id), 32'(id));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    int g;
    logic order [4];
    bus.req0 = 1'b0; bus.a0 = '0; bus.shift0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.shift1 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_z", 32'(bus.z), 32'(0));
    rst_n = 1'b1;

    do_req(1'b0, 5'b10110, 3'd1, 5'b01011, 2, 2, 1'b0, 1'b0);
    do_req(1'b1, 5'b10110, 3'd7, 5'b10101, 3, 3, 1'b1, 1'b0);
    do_req(1'b0, 5'b01101, 3'd5, 5'b01101, 1, 1, 1'b0, 1'b0);
    do_req(1'b0, 5'b00000, 3'd3, 5'b00000, 4, 4, 1'b0, 1'b1);

    // Contention from reset: strict alternation starting with requester 0.
    pulse_reset();
    bus.req0 = 1'b1; bus.a0 = 5'($urandom); bus.shift0 = 3'($urandom);
    bus.req1 = 1'b1; bus.a1 = 5'($urandom); bus.shift1 = 3'($urandom);
    g = 0; k = 0;
    while (g < 4 && k < 100) begin
      @(posedge clk); #1; k++;
      if (saw_ack0 || saw_ack1) begin
        order[g] = saw_ack1;
        g++;
        if (saw_ack1) begin bus.a1 = 5'($urandom); bus.shift1 = 3'($urandom); end
        else          begin bus.a0 = 5'($urandom); bus.shift0 = 3'($urandom); end
      end
    end
    chk("grant_count", 32'(g), 32'(4));
    for (int i = 0; i < g; i++) chk("grant_order", 32'(order[i]), 32'(i % 2));
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset during the second ROT cycle of a 4-step rotation.
    pulse_reset();
    bus.req0 = 1'b1; bus.a0 = 5'b10011; bus.shift0 = 3'd4;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!saw_ack0 && k < 20);
    chk("mid_ack0", 32'(saw_ack0), 32'(1));
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 5'b00111; bus.shift1 = 3'd2;
    @(posedge clk); #1;
    chk("mid_busy_before", 32'(bus.busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'(0));
    chk("mid_done", 32'(bus.done), 32'(0));
    chk("mid_z", 32'(bus.z), 32'(0));
    chk("mid_zf", 32'(bus.zf), 32'(1));
    chk("mid_sf", 32'(bus.sf), 32'(0));
    chk("mid_done_id", 32'(bus.done_id), 32'(0));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack1", 32'(saw_ack1), 32'(1));
    bus.req1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic with rare one-cycle resets.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
      if (saw_ack0) bus.req0 = 1'b0;
      if (saw_ack1) bus.req1 = 1'b0;
      if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1'b1; bus.a0 = 5'($urandom); bus.shift0 = 3'($urandom);
      end
      if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1'b1; bus.a1 = 5'($urandom); bus.shift1 = 3'($urandom);
      end
    end
    rst_n = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ror_seq_ctrl.md
# ror_seq_ctrl

Multi-cycle sequencer that shares one 5-bit rotate-right datapath between two requesters. A round-robin arbiter grants one requester at a time. The granted operand is rotated right one bit position per clock until the requested amount (taken modulo 5) is reached. The block then returns the result with the same z/cf/sf/zf flag set as the combinational 5-bit rotator, plus a one-cycle completion strobe tagged with the requester id. It sits between the CPU's instruction-issue logic and the rotate unit when a registered, low-fan-in rotator is preferred over the full combinational one.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0  in  1  requester 0 request; held high until ack0
- a0  in  5  requester 0 operand
- shift0  in  3  requester 0 rotate amount, 0..7
- req1  in  1  requester 1 request; held high until ack1
- a1  in  5  requester 1 operand
- shift1  in  3  requester 1 rotate amount, 0..7
- ack0  out  1  combinational; high in the cycle requester 0 is accepted
- ack1  out  1  combinational; high in the cycle requester 1 is accepted
- busy  out  1  registered; high in ROT and DONE
- done  out  1  registered; one-cycle pulse, result valid
- done_id  out  1  registered; requester id of the current result
- z  out  5  registered rotate result; holds until next done
- cf  out  1  constant 0
- sf  out  1  z[4]
- zf  out  1  1 when z == 0

## Operation
- Internal state:
  - FSM {IDLE, ROT, DONE}
  - 5-bit accumulator acc
  - 3-bit remaining count rem
  - grant id gid
  - 1-bit priority pointer prio (0 = requester 0 favoured)
- IDLE:
  - No request: stay in IDLE; ack0 = ack1 = 0.
  - Exactly one request: grant that requester.
  - Both requests: grant the requester selected by prio.
  - On grant:
    - ack for the granted requester is asserted in this same cycle.
    - acc <= operand; rem <= shift % 5 (5→0, 6→1, 7→2); gid <= id; prio <= ~id.
    - Next state is ROT if shift % 5 != 0, else DONE.
- ROT:
  - Each cycle: acc <= {acc[0], acc[4:1]} (rotate right by 1); rem <= rem − 1.
  - When rem == 1 this cycle, next state is DONE.
- DONE:
  - z <= acc; done_id <= gid; done pulses for exactly one cycle.
  - Next state is IDLE.
- Requests asserted while busy are neither acked nor lost; they are arbitrated on the next IDLE cycle.
- ack0 and ack1 are never high together and are only high in IDLE.
- Arithmetic: rem never underflows. Amount 0 (or 5) performs zero rotations and returns z = a.

## Timing
- Reset, asserted asynchronously:
  - FSM = IDLE, acc = 0, rem = 0, gid = 0, prio = 0.
  - z = 0, sf = 0, zf = 1, cf = 0, done = 0, done_id = 0, busy = 0.
- Accept in cycle T (ack high):
  - done is high in cycle T + 1 + N, where N = shift % 5 (range 0..4).
  - Latency therefore ranges from 1 to 5 cycles after accept.
- busy is high from T + 1 through T + 1 + N inclusive.
- Issue rate: the earliest next accept is cycle T + 2 + N, which is the IDLE cycle after done. Back-to-back results are separated by at least one cycle.
- z/sf/zf update only on the DONE transition and hold otherwise.
- Reset mid-operation: the operation is abandoned, no done is issued, all outputs return to reset values immediately, and prio returns to 0.

## Test plan
- Reset, then req0 with a0 = 5'b10110, shift0 = 1:
  - ack0 in the request cycle T; done at T + 2.
  - z = 01011, sf = 0, zf = 0, cf = 0, done_id = 0.
- req1 with a1 = 10110, shift1 = 7 (N = 2):
  - done at T + 3; z = 10101, sf = 1, done_id = 1.
  - busy high for exactly 3 cycles.
- req0 with a0 = 5'b01101, shift0 = 5:
  - ROT is skipped; done at T + 1 with z = 01101.
- req0 with a0 = 0, shift0 = 3 → z = 0, zf = 1, sf = 0.
- After reset, req0 and req1 are held high together:
  - Grants in order 0, 1, 0, 1.
  - Never ack0 and ack1 in the same cycle.
  - Each done_id matches its grant order.
- Start req0 with shift0 = 4, then pull rst_n low during the second ROT cycle:
  - All outputs return to reset values asynchronously.
  - No done pulse is issued.
  - After release, a pending req1 is acked first only if req0 is low.
